// File: rtl/pixie_pkg.sv
// Shared geometry, scan FSM state encoding and write-request type for the
// Pixie frame buffer controller.
package pixie_pkg;
  localparam int FB_DEPTH       = 1024;
  localparam int BYTES_PER_LINE = 8;
  localparam int LINES          = 128;
  localparam int ADDR_W         = 10;
  localparam int LINE_W         = 7;
  localparam int BYTE_W         = 3;

  typedef enum logic [1:0] {IDLE, RD0, LD, SHIFT} scan_st_t;

  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } fb_wr_t;

  function automatic logic [ADDR_W-1:0] fb_addr(input logic [LINE_W-1:0] ln,
                                                input logic [BYTE_W-1:0] b);
    return {ln, b};
  endfunction
endpackage

// File: rtl/pixie_fb_scanout.sv
// Line scan sequencer: fetches the 8 bytes of one display line from the
// frame buffer read port and serialises them MSB-first as a pixel stream.
module pixie_fb_scanout
  import pixie_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              display_en,
  input  logic              line_req,
  input  logic [LINE_W-1:0] line_num,
  input  logic              pix_ce,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              line_busy,
  output logic              line_done
);
  scan_st_t          state, state_nx;
  logic [LINE_W-1:0] line_q, line_nx;
  logic [BYTE_W-1:0] byte_idx, byte_nx;
  logic [2:0]        bit_cnt, bit_nx;
  logic [7:0]        shift_q, shift_nx, next_byte;
  logic              pf_pend, pf_nx;
  logic              nb_cap;
  logic              done_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      line_q    <= '0;
      byte_idx  <= '0;
      bit_cnt   <= '0;
      shift_q   <= '0;
      next_byte <= '0;
      pf_pend   <= 1'b0;
      nb_cap    <= 1'b0;
      line_done <= 1'b0;
    end else begin
      state     <= state_nx;
      line_q    <= line_nx;
      byte_idx  <= byte_nx;
      bit_cnt   <= bit_nx;
      shift_q   <= shift_nx;
      pf_pend   <= pf_nx;
      line_done <= done_nx;
      // prefetched bytes land one cycle after their read
      nb_cap    <= fb_rd_en && (state == LD || state == SHIFT);
      if (nb_cap) next_byte <= fb_rd_data;
    end
  end

  always_comb begin
    state_nx   = state;
    line_nx    = line_q;
    byte_nx    = byte_idx;
    bit_nx     = bit_cnt;
    shift_nx   = shift_q;
    pf_nx      = 1'b0;
    done_nx    = 1'b0;
    fb_rd_en   = 1'b0;
    fb_rd_addr = fb_addr(line_q, 3'd0);
    case (state)
      RD0: begin
        fb_rd_en = 1'b1;
        state_nx = LD;
      end
      LD: begin
        fb_rd_en   = 1'b1;
        fb_rd_addr = fb_addr(line_q, 3'd1);
        shift_nx   = fb_rd_data;
        bit_nx     = 3'd0;
        state_nx   = SHIFT;
      end
      SHIFT: begin
        // byte_idx already advanced, so +1 is two ahead of the old byte
        if (pf_pend) begin
          fb_rd_en   = 1'b1;
          fb_rd_addr = fb_addr(line_q, byte_idx + 3'd1);
        end
        if (pix_ce) begin
          if (bit_cnt == 3'd7) begin
            if (byte_idx == 3'd7) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end else begin
              shift_nx = next_byte;
              byte_nx  = byte_idx + 3'd1;
              bit_nx   = 3'd0;
              pf_nx    = (byte_idx <= 3'd5);
            end
          end else begin
            shift_nx = {shift_q[6:0], 1'b0};
            bit_nx   = bit_cnt + 3'd1;
          end
        end
      end
      default: ;
    endcase
    if (line_req && display_en) begin
      state_nx = RD0;
      line_nx  = line_num;
      byte_nx  = 3'd0;
      pf_nx    = 1'b0;
      done_nx  = 1'b0;
    end
    if (!display_en) begin
      state_nx = IDLE;
      pf_nx    = 1'b0;
      done_nx  = 1'b0;
    end
  end

  assign pixel_valid = (state == SHIFT);
  assign pixel       = pixel_valid & shift_q[7];
  assign line_busy   = (state != IDLE);
endmodule

// File: rtl/pixie_fb_ctrl.sv
// Pixie frame buffer controller: linear DMA write sequencer plus the line
// scan-out sequencer on the read port.
module pixie_fb_ctrl
  import pixie_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              frame_start,
  input  logic              dma_valid,
  input  logic [7:0]        dma_data,
  input  logic              display_en,
  input  logic              line_req,
  input  logic [LINE_W-1:0] line_num,
  input  logic              pix_ce,
  output logic              fb_wr_en,
  output logic [ADDR_W-1:0] fb_wr_addr,
  output logic [7:0]        fb_wr_data,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_rd_addr,
  input  logic [7:0]        fb_rd_data,
  output logic              pixel,
  output logic              pixel_valid,
  output logic              line_busy,
  output logic              line_done,
  output logic              wr_overflow
);
  fb_wr_t          wr_q;
  logic [ADDR_W:0] wr_ptr;

  // wr_ptr[ADDR_W] set means the frame is full and further bytes drop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q        <= '0;
      wr_ptr      <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_q.en <= 1'b0;
      if (frame_start) begin
        wr_overflow <= 1'b0;
        wr_ptr      <= {{ADDR_W{1'b0}}, dma_valid};
        if (dma_valid) wr_q <= '{en: 1'b1, addr: '0, data: dma_data};
      end else if (dma_valid) begin
        if (!wr_ptr[ADDR_W]) begin
          wr_q   <= '{en: 1'b1, addr: wr_ptr[ADDR_W-1:0], data: dma_data};
          wr_ptr <= wr_ptr + 11'd1;
        end else begin
          wr_overflow <= 1'b1;
        end
      end
    end
  end

  assign fb_wr_en   = wr_q.en;
  assign fb_wr_addr = wr_q.addr;
  assign fb_wr_data = wr_q.data;

  pixie_fb_scanout u_scan (
    .clk        (clk),
    .reset_n    (reset_n),
    .display_en (display_en),
    .line_req   (line_req),
    .line_num   (line_num),
    .pix_ce     (pix_ce),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .pixel      (pixel),
    .pixel_valid(pixel_valid),
    .line_busy  (line_busy),
    .line_done  (line_done)
  );
endmodule

// File: tb/tb_pixie_fb_ctrl.sv
// Randomised bench for pixie_fb_ctrl with a frame buffer RAM model and a
// byte-count / bit-list reference for writes and scanned pixels.
module tb_pixie_fb_ctrl;
  logic       clk = 1'b0, reset_n = 1'b0;
  logic       frame_start = 1'b0, dma_valid = 1'b0, display_en = 1'b0;
  logic       line_req = 1'b0, pix_ce = 1'b0;
  logic [7:0] dma_data = '0;
  logic [6:0] line_num = '0;
  logic       fb_wr_en, fb_rd_en;
  logic [9:0] fb_wr_addr, fb_rd_addr;
  logic [7:0] fb_wr_data;
  logic [7:0] fb_rd_data = '0;
  logic       pixel, pixel_valid, line_busy, line_done, wr_overflow;

  int total = 0, bad = 0;
  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];
  logic       bd_we = 1'b0;
  logic [9:0] bd_addr = '0;
  logic [7:0] bd_data = '0;
  int         m_cnt = 0;
  bit         m_ovf = 1'b0;

  pixie_fb_ctrl dut (
    .clk(clk), .reset_n(reset_n), .frame_start(frame_start),
    .dma_valid(dma_valid), .dma_data(dma_data), .display_en(display_en),
    .line_req(line_req), .line_num(line_num), .pix_ce(pix_ce),
    .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_rd_en(fb_rd_en), .fb_rd_addr(fb_rd_addr), .fb_rd_data(fb_rd_data),
    .pixel(pixel), .pixel_valid(pixel_valid), .line_busy(line_busy),
    .line_done(line_done), .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fb_wr_en) mem[fb_wr_addr] <= fb_wr_data;
    if (bd_we)    mem[bd_addr]    <= bd_data;
    if (fb_rd_en) fb_rd_data      <= mem[fb_rd_addr];
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero();
    chk("z_wr_en", fb_wr_en, 0);     chk("z_wr_addr", fb_wr_addr, 0);
    chk("z_wr_data", fb_wr_data, 0); chk("z_rd_en", fb_rd_en, 0);
    chk("z_rd_addr", fb_rd_addr, 0); chk("z_pixel", pixel, 0);
    chk("z_pv", pixel_valid, 0);     chk("z_busy", line_busy, 0);
    chk("z_done", line_done, 0);     chk("z_ovf", wr_overflow, 0);
  endtask

  // One DMA-side cycle: bytes accepted this frame land at consecutive addresses.
  task automatic step_wr(input bit fs, input bit dv, input logic [7:0] d);
    bit exp_en;
    int exp_a;
    frame_start = fs; dma_valid = dv; dma_data = d;
    cyc();
    frame_start = 1'b0; dma_valid = 1'b0;
    exp_en = 1'b0; exp_a = 0;
    if (fs) begin
      m_cnt = 0; m_ovf = 1'b0;
    end
    if (dv) begin
      if (m_cnt < 1024) begin
        exp_en = 1'b1; exp_a = m_cnt; ref_mem[m_cnt] = d; m_cnt++;
      end else m_ovf = 1'b1;
    end
    chk("wr_en", fb_wr_en, exp_en);
    if (exp_en) begin
      chk("wr_addr", fb_wr_addr, exp_a);
      chk("wr_data", fb_wr_data, d);
    end
    chk("wr_ovf", wr_overflow, m_ovf);
  endtask

  task automatic bd_load(input int a, input logic [7:0] d);
    bd_we = 1'b1; bd_addr = a[9:0]; bd_data = d;
    cyc();
    bd_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Scan a line; p = pix_ce period (0 = random). Starts with line_req now.
  task automatic scan_line(input int ln, input int p);
    int base, rd_n, px_n, done_n, gaps, k, last_ce, done_k;
    logic [7:0] b;
    base = ln * 8; rd_n = 1; px_n = 0; done_n = 0; gaps = 0; k = 0;
    last_ce = -100; done_k = -1;
    pix_ce = 1'b0; line_req = 1'b1; line_num = ln[6:0];
    cyc();
    line_req = 1'b0;
    chk("rd0_en", fb_rd_en, 1);
    chk("rd0_addr", fb_rd_addr, base);
    chk("rd0_pv", pixel_valid, 0);
    chk("rd0_busy", line_busy, 1);
    cyc();
    chk("ld_pv", pixel_valid, 0);
    while (done_n == 0 && k < 800) begin
      if (fb_rd_en) begin
        chk("rd_addr", fb_rd_addr, base + rd_n);
        rd_n++;
      end
      if (line_done) begin
        done_n++; done_k = k;
      end
      if (k >= 1 && px_n < 64 && !pixel_valid) gaps++;
      if (!pixel_valid) chk("px_idle", pixel, 0);
      pix_ce = (p == 0) ? 1'($urandom_range(0, 1)) : (k % p == p - 1);
      if (pixel_valid && pix_ce) begin
        b = ref_mem[base + px_n / 8];
        chk("px", pixel, b[7 - px_n % 8]);
        px_n++; last_ce = k;
      end
      if (done_n == 0) begin
        cyc();
        k++;
      end
    end
    pix_ce = 1'b0;
    chk("done_seen", done_n, 1);
    chk("px_cnt", px_n, 64);
    chk("rd_cnt", rd_n, 8);
    chk("gaps", gaps, 0);
    chk("done_lat", done_k, last_ce + 1);
    chk("end_busy", line_busy, 0);
  endtask

  initial begin
    int n;
    logic [7:0] pat [8];
    pat = '{8'h80, 8'h01, 8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h0F, 8'hF0};
    repeat (2) @(posedge clk);
    #1;
    chk_zero();
    @(negedge clk);
    reset_n = 1'b1; display_en = 1'b1;
    cyc();

    // sequential fill with random idle gaps, then overflow and clear
    step_wr(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 7) == 0) step_wr(1'b0, 1'b0, 8'h00);
      step_wr(1'b0, 1'b1, i[7:0]);
    end
    step_wr(1'b0, 1'b1, 8'h55);
    chk("ovf_set", wr_overflow, 1);
    step_wr(1'b1, 1'b0, 8'h00);
    chk("ovf_clr", wr_overflow, 0);
    step_wr(1'b1, 1'b1, 8'hAA);
    step_wr(1'b0, 1'b1, 8'h3C);
    repeat (2500)
      step_wr($urandom_range(0, 1499) == 0, $urandom_range(0, 3) != 0, 8'($urandom));
    step_wr(1'b0, 1'b0, 8'h00);

    // line 5 fixed pattern, every cycle and every third cycle
    for (int i = 0; i < 8; i++) bd_load(40 + i, pat[i]);
    scan_line(5, 1);
    scan_line(5, 3);
    repeat (6) scan_line($urandom_range(0, 127), $urandom_range(0, 4));

    // abort line 5 mid-line with a request for line 7
    n = 0;
    line_req = 1'b1; line_num = 7'd5;
    cyc();
    line_req = 1'b0; pix_ce = 1'b1;
    repeat (25) begin
      cyc();
      if (line_done) n++;
    end
    scan_line(7, 1);
    chk("abort_no_done", n, 0);

    // display disabled mid-line
    n = 0;
    line_req = 1'b1; line_num = 7'd3;
    cyc();
    line_req = 1'b0; pix_ce = 1'b1;
    repeat (12) cyc();
    chk("off_pre_pv", pixel_valid, 1);
    display_en = 1'b0;
    cyc();
    chk("off_busy", line_busy, 0);
    chk("off_pv", pixel_valid, 0);
    chk("off_px", pixel, 0);
    line_req = 1'b1; line_num = 7'd4;
    cyc();
    line_req = 1'b0;
    chk("off_ignore", line_busy, 0);
    repeat (70) begin
      cyc();
      if (line_done || fb_rd_en || pixel_valid) n++;
    end
    chk("off_quiet", n, 0);
    display_en = 1'b1; pix_ce = 1'b0;
    cyc();

    // async reset during SHIFT with overflow set
    step_wr(1'b1, 1'b0, 8'h00);
    repeat (1025) step_wr(1'b0, 1'b1, 8'($urandom));
    step_wr(1'b0, 1'b1, 8'h77);
    chk("pre_rst_ovf", wr_overflow, 1);
    line_req = 1'b1; line_num = 7'd9;
    cyc();
    line_req = 1'b0; pix_ce = 1'b1;
    repeat (10) cyc();
    chk("pre_rst_pv", pixel_valid, 1);
    #2 reset_n = 1'b0;
    #1 chk_zero();
    @(negedge clk);
    reset_n = 1'b1; pix_ce = 1'b0;
    m_cnt = 0; m_ovf = 1'b0;
    cyc();
    chk("post_rst_busy", line_busy, 0);
    step_wr(1'b0, 1'b1, 8'h11);
    scan_line(9, 1);
    scan_line(9, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
